// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-side bundle handshake into the issue stage and the registered ALU bundle out of it
interface alu_issue_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [6:0]               opcode;
  logic [2:0]               funct3;
  logic                     funct7_b5;
  logic [DATA_WIDTH-1:0]    rs1_data;
  logic [DATA_WIDTH-1:0]    rs2_data;
  logic [DATA_WIDTH-1:0]    imm;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    SrcA;
  logic [DATA_WIDTH-1:0]    SrcB;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     illegal;
  modport master (
    output flush, in_valid, opcode, funct3, funct7_b5, rs1_data, rs2_data, imm, out_ready,
    input  in_ready, out_valid, SrcA, SrcB, Operation, illegal
  );
  modport slave (
    input  flush, in_valid, opcode, funct3, funct7_b5, rs1_data, rs2_data, imm, out_ready,
    output in_ready, out_valid, SrcA, SrcB, Operation, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I fields into an ALU op, picks SrcB, and registers the bundle behind valid/ready with flush
module alu_issue_stage #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  alu_issue_if.slave io
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011;
  localparam logic [3:0] ILL = 4'b1111;
  logic [3:0]               alu_op, br_op, dec_op;
  logic                     dec_imm, dec_ill, accept, in_ready;
  logic                     valid_d, valid_q, ill_d, ill_q;
  logic [DATA_WIDTH-1:0]    src_a_d, src_a_q, src_b_d, src_b_q;
  logic [OPCODE_LENGTH-1:0] op_d, op_q;
  always_comb begin
    case (io.funct3)
      3'b000:  alu_op = io.funct7_b5 ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b1000;
      3'b010:  alu_op = 4'b0101;
      3'b100:  alu_op = 4'b0010;
      3'b101:  alu_op = io.funct7_b5 ? 4'b0110 : 4'b0111;
      3'b110:  alu_op = 4'b0011;
      3'b111:  alu_op = 4'b0100;
      default: alu_op = ILL;
    endcase
    case (io.funct3)
      3'b000:  br_op = 4'b1101;
      3'b001:  br_op = 4'b1010;
      3'b100:  br_op = 4'b1011;
      3'b101:  br_op = 4'b1100;
      default: br_op = ILL;
    endcase
    case (io.opcode)
      OP_R:         dec_op = alu_op;
      OP_I:         dec_op = io.funct3 == 3'b000 ? 4'b0000 :
                             (io.funct3 == 3'b001 && io.funct7_b5) ? ILL : alu_op;
      OP_LD, OP_ST: dec_op = 4'b0000;
      OP_BR:        dec_op = br_op;
      default:      dec_op = ILL;
    endcase
    dec_ill = dec_op == ILL;
    // illegal bundles always carry rs2 so the trap handler sees a predictable operand
    dec_imm = !dec_ill && (io.opcode == OP_I || io.opcode == OP_LD || io.opcode == OP_ST);
  end
  always_comb begin
    in_ready = !io.flush && (!valid_q || io.out_ready);
    accept   = io.in_valid && in_ready;
    valid_d  = io.flush ? 1'b0 : accept ? 1'b1 : io.out_ready ? 1'b0 : valid_q;
    src_a_d  = accept ? io.rs1_data : src_a_q;
    src_b_d  = accept ? (dec_imm ? io.imm : io.rs2_data) : src_b_q;
    op_d     = accept ? OPCODE_LENGTH'(dec_op) : op_q;
    ill_d    = accept ? dec_ill : ill_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      src_a_q <= '0;
      src_b_q <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
    end
  end
  assign io.in_ready  = in_ready;
  assign io.out_valid = valid_q;
  assign io.SrcA      = src_a_q;
  assign io.SrcB      = src_b_q;
  assign io.Operation = op_q;
  assign io.illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed plus random stimulus checked against a table-driven issue-stage model
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  alu_issue_if io ();
  alu_issue_stage dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  localparam logic [3:0] F = 4'hF;
  localparam logic [3:0] ALU_TAB [8] = '{4'h0, 4'h8, 4'h5, F, 4'h2, 4'h7, 4'h3, 4'h4};
  localparam logic [3:0] BR_TAB  [8] = '{4'hD, 4'hA, F, F, 4'hB, 4'hC, F, F};
  localparam logic [6:0] OPC [8] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                     7'b1100011, 7'b0110111, 7'b1101111, 7'b0000000};
  logic        mv, mill;
  logic [31:0] ma, mb;
  logic [3:0]  mop;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [3:0] ref_op(input logic [6:0] opc, input logic [2:0] f3, input logic b5);
    logic [3:0] op;
    op = F;
    if (opc == 7'b0110011) begin
      op = ALU_TAB[f3];
      if (b5 && f3 == 3'd0) op = 4'h1;
      if (b5 && f3 == 3'd5) op = 4'h6;
    end else if (opc == 7'b0010011) begin
      op = ALU_TAB[f3];
      if (b5 && f3 == 3'd5) op = 4'h6;
      if (b5 && f3 == 3'd1) op = F;
    end else if (opc == 7'b0000011 || opc == 7'b0100011) op = 4'h0;
    else if (opc == 7'b1100011) op = BR_TAB[f3];
    return op;
  endfunction
  task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3, input logic b5,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    io.in_valid = v; io.opcode = opc; io.funct3 = f3; io.funct7_b5 = b5;
    io.rs1_data = a; io.rs2_data = b; io.imm = im;
  endtask
  task automatic cycle();
    logic rdy;
    logic [3:0] op;
    @(negedge clk);
    rdy = !io.flush && (!mv || io.out_ready);
    chk("in_ready", io.in_ready, rdy);
    chk("out_valid", io.out_valid, mv);
    if (mv) begin
      chk("SrcA", io.SrcA, ma);
      chk("SrcB", io.SrcB, mb);
      chk("Operation", io.Operation, mop);
      chk("illegal", io.illegal, mill);
    end
    @(posedge clk);
    if (io.flush) mv = 1'b0;
    else if (io.in_valid && rdy) begin
      op   = ref_op(io.opcode, io.funct3, io.funct7_b5);
      mv   = 1'b1;
      ma   = io.rs1_data;
      mop  = op;
      mill = op == F;
      mb   = (op != F && io.opcode inside {7'b0010011, 7'b0000011, 7'b0100011}) ? io.imm : io.rs2_data;
    end else if (io.out_ready) mv = 1'b0;
    #1;
  endtask
  initial begin
    mv = 0; ma = 0; mb = 0; mop = 0; mill = 0;
    io.flush = 0; io.out_ready = 0;
    drive(1, 7'b0110011, 3'd0, 0, 32'd1, 32'd2, 32'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", io.out_valid, 0);
    chk("rst_op", io.Operation, 0);
    chk("rst_srca", io.SrcA, 0);
    chk("rst_srcb", io.SrcB, 0);
    chk("rst_ill", io.illegal, 0);
    io.in_valid = 0;
    rst_n = 1;
    #1 chk("rst_ready", io.in_ready, 1);
    @(posedge clk); #1;
    io.out_ready = 1;
    drive(1, 7'b0110011, 3'd0, 1, 32'd5, 32'd3, 32'd99);
    cycle();
    chk("sub_valid", io.out_valid, 1);
    chk("sub_op", io.Operation, 4'b0001);
    chk("sub_a", io.SrcA, 5);
    chk("sub_b", io.SrcB, 3);
    drive(1, 7'b0010011, 3'd5, 1, 32'd8, 32'd77, 32'd2);
    cycle();
    chk("srai_op", io.Operation, 4'b0110);
    chk("srai_b", io.SrcB, 2);
    drive(1, 7'b1100011, 3'd5, 0, 32'd4, 32'd9, 32'd123);
    cycle();
    chk("bge_op", io.Operation, 4'b1100);
    chk("bge_b", io.SrcB, 9);
    drive(1, 7'b0000011, 3'd2, 0, 32'd40, 32'd6, 32'hFFFF_FFFC);
    cycle();
    chk("ld_op", io.Operation, 4'b0000);
    chk("ld_b", io.SrcB, 32'hFFFF_FFFC);
    io.out_ready = 0;
    drive(1, 7'b0110011, 3'd4, 0, 32'd11, 32'd12, 32'd13);
    repeat (3) begin
      cycle();
      chk("stall_ready", io.in_ready, 0);
      chk("stall_a", io.SrcA, 40);
      chk("stall_b", io.SrcB, 32'hFFFF_FFFC);
      chk("stall_op", io.Operation, 0);
    end
    io.out_ready = 1;
    cycle();
    chk("unstall_a", io.SrcA, 11);
    chk("unstall_op", io.Operation, 4'b0010);
    io.flush = 1;
    drive(1, 7'b0110011, 3'd6, 0, 32'd21, 32'd22, 32'd23);
    cycle();
    chk("flush_valid", io.out_valid, 0);
    io.flush = 0;
    drive(1, 7'b0110011, 3'd3, 0, 32'd31, 32'd32, 32'd33);
    cycle();
    chk("ill_flag", io.illegal, 1);
    chk("ill_op", io.Operation, 4'hF);
    chk("ill_b", io.SrcB, 32);
    for (int i = 0; i < 3000; i++) begin
      io.flush = $urandom_range(9) == 0;
      io.out_ready = $urandom_range(9) < 6;
      drive($urandom_range(9) < 7, ($urandom_range(7) == 0) ? 7'($urandom) : OPC[$urandom_range(7)],
            3'($urandom), 1'($urandom), $urandom, $urandom, $urandom);
      cycle();
    end
    io.flush = 0; io.out_ready = 1;
    drive(1, 7'b0010011, 3'd7, 0, 32'd55, 32'd56, 32'd57);
    cycle();
    io.out_ready = 0; io.in_valid = 0;
    cycle();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", io.out_valid, 0);
    chk("arst_a", io.SrcA, 0);
    mv = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
